// File: rtl/layer_train_driver_pkg.sv
// Shared types and helpers for the layer training driver and its argmax scanner.
package layer_train_driver_pkg;

    typedef logic [7:0] zero2one_t;

    localparam zero2one_t ZERO2ONE_ONE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        SCAN,
        LEARN,
        WRAP,
        DONE
    } drv_state_t;

    function automatic int lbl_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/layer_train_driver_seq_argmax.sv
// Sequential argmax over M elements, one element per step; ties keep the lowest index.
module seq_argmax
    import layer_train_driver_pkg::*;
#(
    parameter int M     = 37,
    parameter int LBL_W = lbl_w(M)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  zero2one_t        elem,
    output logic [LBL_W-1:0] idx,
    output logic             last,
    output logic [LBL_W-1:0] result_idx
);

    logic [LBL_W-1:0] idx_q, idx_d;
    logic [LBL_W-1:0] best_idx_q, best_idx_d;
    zero2one_t        best_val_q, best_val_d;
    logic             take;

    // Element 0 always loads so a stale best from a previous scan never survives.
    always_comb begin
        take       = step && ((idx_q == '0) || (elem > best_val_q));
        last       = (idx_q == LBL_W'(M - 1));
        result_idx = take ? idx_q : best_idx_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        if (start) begin
            idx_d = '0;
        end else if (step) begin
            idx_d = last ? '0 : idx_q + 1'b1;
            if (take) begin
                best_idx_d = idx_q;
                best_val_d = elem;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/layer_train_driver.sv
// Initiator for a neuron_learn layer: present sample, settle, argmax, pulse learn, count accuracy.
// ERROR_DRIVEN_EN: when defined, the learn cycle is skipped for correctly predicted samples.
module layer_train_driver
    import layer_train_driver_pkg::*;
#(
    parameter int N      = 16,
    parameter int M      = 37,
    parameter int SETTLE = 2,
    parameter int EPOCHS = 4,
    localparam int LBL_W = lbl_w(M)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  zero2one_t [N-1:0]     s_in,
    input  logic [LBL_W-1:0]      s_label,
    input  logic                  s_last,
    output logic                  valid,
    output logic                  learn,
    output zero2one_t [N-1:0]     in,
    input  zero2one_t [M-1:0]     out,
    output zero2one_t [M-1:0]     expected_out,
    output logic [LBL_W-1:0]      pred,
    output logic [15:0]           correct_cnt,
    output logic [15:0]           sample_cnt,
    output logic [15:0]           epoch,
    output logic                  done
);

    drv_state_t        state_q, state_d;
    logic              s_ready_q, s_ready_d, valid_q, valid_d, learn_q, learn_d;
    logic              done_q, done_d, last_q, last_d;
    zero2one_t [N-1:0] in_q, in_d;
    zero2one_t [M-1:0] expected_out_q, expected_out_d;
    logic [LBL_W-1:0]  lbl_q, lbl_d, pred_q, pred_d, lbl_in;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       correct_q, correct_d, sample_q, sample_d, epoch_q, epoch_d;
    logic              scan_start, scan_step, scan_last, skip_learn;
    logic [LBL_W-1:0]  scan_idx, scan_result;

    seq_argmax #(.M(M), .LBL_W(LBL_W)) u_argmax (
        .clock      (clock),
        .reset      (reset),
        .start      (scan_start),
        .step       (scan_step),
        .elem       (out[scan_idx]),
        .idx        (scan_idx),
        .last       (scan_last),
        .result_idx (scan_result)
    );

    always_comb begin
        lbl_in = (32'(s_label) >= 32'(M)) ? LBL_W'(M - 1) : s_label;
`ifdef ERROR_DRIVEN_EN
        skip_learn = (scan_result == lbl_q);
`else
        skip_learn = 1'b0;
`endif
    end

    always_comb begin
        state_d        = state_q;
        s_ready_d      = s_ready_q;
        valid_d        = valid_q;
        learn_d        = 1'b0;
        expected_out_d = '0;
        done_d         = done_q;
        in_d           = in_q;
        lbl_d          = lbl_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        pred_d         = pred_q;
        correct_d      = correct_q;
        sample_d       = sample_q;
        epoch_d        = epoch_q;
        scan_start     = 1'b0;
        scan_step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    in_d       = s_in;
                    lbl_d      = lbl_in;
                    last_d     = s_last;
                    cnt_d      = 4'(SETTLE - 1);
                    s_ready_d  = 1'b0;
                    valid_d    = 1'b1;
                    scan_start = 1'b1;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q == '0) state_d = SCAN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SCAN: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    pred_d   = scan_result;
                    sample_d = (sample_q == 16'hFFFF) ? sample_q : sample_q + 16'd1;
                    if (scan_result == lbl_q)
                        correct_d = (correct_q == 16'hFFFF) ? correct_q : correct_q + 16'd1;
                    if (skip_learn) begin
                        valid_d   = 1'b0;
                        s_ready_d = !last_q;
                        state_d   = last_q ? WRAP : IDLE;
                    end else begin
                        learn_d               = 1'b1;
                        expected_out_d[lbl_q] = ZERO2ONE_ONE;
                        state_d               = LEARN;
                    end
                end
            end
            LEARN: begin
                valid_d   = 1'b0;
                s_ready_d = !last_q;
                state_d   = last_q ? WRAP : IDLE;
            end
            WRAP: begin
                epoch_d   = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
                correct_d = '0;
                sample_d  = '0;
                if (32'(epoch_q) + 32'd1 == 32'(EPOCHS)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    s_ready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                s_ready_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            s_ready_q      <= 1'b1;
            valid_q        <= 1'b0;
            learn_q        <= 1'b0;
            expected_out_q <= '0;
            done_q         <= 1'b0;
            in_q           <= '0;
            lbl_q          <= '0;
            last_q         <= 1'b0;
            cnt_q          <= '0;
            pred_q         <= '0;
            correct_q      <= '0;
            sample_q       <= '0;
            epoch_q        <= '0;
        end else begin
            state_q        <= state_d;
            s_ready_q      <= s_ready_d;
            valid_q        <= valid_d;
            learn_q        <= learn_d;
            expected_out_q <= expected_out_d;
            done_q         <= done_d;
            in_q           <= in_d;
            lbl_q          <= lbl_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            pred_q         <= pred_d;
            correct_q      <= correct_d;
            sample_q       <= sample_d;
            epoch_q        <= epoch_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign valid        = valid_q;
    assign learn        = learn_q;
    assign in           = in_q;
    assign expected_out = expected_out_q;
    assign pred         = pred_q;
    assign correct_cnt  = correct_q;
    assign sample_cnt   = sample_q;
    assign epoch        = epoch_q;
    assign done         = done_q;

endmodule

// File: tb/tb_layer_train_driver.sv
// Randomized bench for layer_train_driver: a timeline model of each sample predicts every output per cycle.
module tb_layer_train_driver;
    import layer_train_driver_pkg::*;

    localparam int N      = 16;
    localparam int M      = 37;
    localparam int SETTLE = 2;
    localparam int EPOCHS = 2;
    localparam int LBL_W  = lbl_w(M);
    localparam int LAT    = SETTLE + M + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    zero2one_t [N-1:0] s_in = '0;
    logic [LBL_W-1:0]  s_label = '0;
    logic              s_last = 1'b0;
    logic              valid, learn, done;
    zero2one_t [N-1:0] layer_in;
    zero2one_t [M-1:0] layer_out = '0;
    zero2one_t [M-1:0] expected_out;
    logic [LBL_W-1:0]  pred;
    logic [15:0]       correct_cnt, sample_cnt, epoch;

    int compared   = 0;
    int mismatched = 0;

    layer_train_driver #(.N(N), .M(M), .SETTLE(SETTLE), .EPOCHS(EPOCHS)) dut (
        .clock        (clock),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_in         (s_in),
        .s_label      (s_label),
        .s_last       (s_last),
        .valid        (valid),
        .learn        (learn),
        .in           (layer_in),
        .out          (layer_out),
        .expected_out (expected_out),
        .pred         (pred),
        .correct_cnt  (correct_cnt),
        .sample_cnt   (sample_cnt),
        .epoch        (epoch),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Model: each accepted sample is a timeline of cycles counted from its handshake edge.
    bit                m_busy, m_done, m_last, m_learn;
    int                m_k, m_lbl, m_best, m_pred, m_corr, m_samp, m_epoch, m_hs;
    zero2one_t [N-1:0] m_in;

    function automatic int argmaxRef(input zero2one_t [M-1:0] v);
        int best = 0;
        for (int i = 1; i < M; i++) if (v[i] > v[best]) best = i;
        return best;
    endfunction

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic modelReset();
        m_busy = 0; m_done = 0; m_last = 0; m_learn = 0; m_k = 0;
        m_lbl = 0; m_best = 0; m_pred = 0; m_corr = 0; m_samp = 0; m_epoch = 0;
        m_in = '0;
    endtask

    initial begin
        m_hs = 0;
        modelReset();
        forever begin
            @(posedge clock);
            if (reset) begin
                modelReset();
            end else if (m_busy) begin
                m_k++;
                if (m_k == LAT) begin
                    m_pred = m_best;
                    m_samp = sat16(m_samp + 1);
                    if (m_best == m_lbl) m_corr = sat16(m_corr + 1);
                end
                if (!m_last && m_k == LAT + int'(m_learn)) m_busy = 0;
                if (m_last && m_k == LAT + int'(m_learn) + 1) begin
                    m_epoch = sat16(m_epoch + 1);
                    m_corr  = 0;
                    m_samp  = 0;
                    m_busy  = 0;
                    if (m_epoch == EPOCHS) m_done = 1;
                end
            end else if (!m_done && s_valid) begin
                m_busy = 1;
                m_k    = 1;
                m_in   = s_in;
                m_lbl  = (int'(s_label) >= M) ? M - 1 : int'(s_label);
                m_last = s_last;
                m_best = argmaxRef(layer_out);
`ifdef ERROR_DRIVEN_EN
                m_learn = (m_best != m_lbl);
`else
                m_learn = 1;
`endif
                m_hs++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic boundFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, want event at %0t", name, $time);
    endtask

    // Every cycle, compare all outputs with the model on the falling edge.
    initial begin
        bit                exp_valid, exp_learn;
        zero2one_t [M-1:0] exp_eo;
        forever begin
            @(negedge clock);
            exp_learn = m_busy && (m_k == LAT) && m_learn;
            exp_valid = m_busy && ((m_k < LAT) || exp_learn);
            exp_eo    = '0;
            if (exp_learn) exp_eo[m_lbl] = 8'hFF;
            checkOutput("s_ready", 320'(s_ready), 320'(!m_busy && !m_done));
            checkOutput("valid", 320'(valid), 320'(exp_valid));
            checkOutput("learn", 320'(learn), 320'(exp_learn));
            checkOutput("expected_out", 320'(expected_out), 320'(exp_eo));
            checkOutput("in", 320'(layer_in), 320'(m_in));
            checkOutput("pred", 320'(pred), 320'(m_pred));
            checkOutput("correct_cnt", 320'(correct_cnt), 320'(m_corr));
            checkOutput("sample_cnt", 320'(sample_cnt), 320'(m_samp));
            checkOutput("epoch", 320'(epoch), 320'(m_epoch));
            checkOutput("done", 320'(done), 320'(m_done));
        end
    end

    task automatic applyStimulus(input int label, input bit last);
        int start;
        int n;
        @(negedge clock);
        s_valid = 1'b1;
        for (int i = 0; i < N; i++) s_in[i] = zero2one_t'($urandom_range(0, 255));
        s_label = LBL_W'(label);
        s_last  = last;
        start   = m_hs;
        n       = 0;
        while (m_hs == start && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (m_hs == start) boundFail("handshake");
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (m_busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (m_busy) boundFail("sample_complete");
    endtask

    task automatic waitLearn(output int n);
        n = 1;
        while (learn !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic randomSample(input bit last);
        int lbl = $urandom_range(0, 39);
        int tgt = (lbl >= M) ? M - 1 : lbl;
        @(negedge clock);
        for (int i = 0; i < M; i++) layer_out[i] = zero2one_t'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) layer_out[tgt] = 8'hFF;
        if ($urandom_range(0, 3) == 0) layer_out[$urandom_range(0, M - 1)] = 8'hFF;
        repeat ($urandom_range(0, 3)) @(negedge clock);
        applyStimulus(lbl, last);
        waitIdle();
    endtask

    initial begin
        int n;
        zero2one_t [M-1:0] eo_rest;
        repeat (3) @(negedge clock);
        checkOutput("reset_s_ready", 320'(s_ready), 320'(1));
        checkOutput("reset_valid", 320'(valid), 320'(0));
        reset = 1'b0;

        // Label 5, silent layer: learn lands exactly SETTLE+M+1 cycles after the handshake.
        applyStimulus(5, 1'b0);
        waitLearn(n);
        checkOutput("learn_latency", 320'(n), 320'(40));
        checkOutput("onehot_5", 320'(expected_out[5]), 320'(8'hFF));
        eo_rest    = expected_out;
        eo_rest[5] = '0;
        checkOutput("onehot_rest_zero", 320'(eo_rest), 320'(0));
        waitIdle();
        checkOutput("pred_silent", 320'(pred), 320'(0));

        // Tie between 12 and 20 resolves to 12, which matches the label.
        @(negedge clock);
        layer_out     = '0;
        layer_out[12] = 8'hFF;
        layer_out[20] = 8'hFF;
        applyStimulus(12, 1'b0);
        waitIdle();
        checkOutput("pred_tie", 320'(pred), 320'(12));
        checkOutput("correct_after_tie", 320'(correct_cnt), 320'(1));
        checkOutput("samples_after_tie", 320'(sample_cnt), 320'(2));

        // Out-of-range label is clamped to the last class.
        @(negedge clock);
        layer_out = '0;
        applyStimulus(40, 1'b0);
        waitLearn(n);
        checkOutput("clamp_onehot_36", 320'(expected_out[36]), 320'(8'hFF));
        waitIdle();

        for (int s = 0; s < 10; s++) randomSample(s == 9);
        checkOutput("epoch_after_wrap", 320'(epoch), 320'(1));
        checkOutput("samples_cleared", 320'(sample_cnt), 320'(0));

        for (int s = 0; s < 4; s++) randomSample(s == 3);
        checkOutput("done_level", 320'(done), 320'(1));
        s_valid = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("done_blocks_ready", 320'(s_ready), 320'(0));
        s_valid = 1'b0;

        // Reset in the middle of a scan aborts the sample without a learn pulse.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        layer_out = '0;
        applyStimulus(7, 1'b0);
        repeat (SETTLE + 5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort_s_ready", 320'(s_ready), 320'(1));
        checkOutput("abort_learn", 320'(learn), 320'(0));
        checkOutput("abort_samples", 320'(sample_cnt), 320'(0));
        for (int s = 0; s < 5; s++) randomSample(1'b0);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
